// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// UART receive framer placed directly after the rx falling-edge detector.
// Leaves IDLE on the detector's start-edge pulse, re-checks the start bit at
// mid-bit, then shifts in DATA_BITS data bits LSB first. An optional parity
// bit follows, then the stop bit. The received word is presented with a
// one-cycle strobe: rx_valid for a good stop bit, rx_frame_err for a low one.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> PARITY state present, parity checked (even/odd by PARITY_ODD)
//   undefined -> no parity bit in the frame, rx_parity_err tied low
//
// Parameters:
//   BAUD_DIV   clock cycles per UART bit (>= 4)
//   DATA_BITS  data bits per frame (5..8)
//   PARITY_ODD 0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk            system clock, rising edge
//   arst_n         asynchronous active-low reset
//   rx             serial line, already synchronised to clk, idle high
//   rx_negedge_det one-cycle start-edge pulse from the edge detector
//   rx_data        last received word, LSB = first bit on the line
//   rx_valid       one-cycle strobe: frame received with a good stop bit
//   rx_frame_err   one-cycle strobe: stop bit sampled low
//   rx_parity_err  one-cycle strobe: parity mismatch, coincident with
//                  rx_valid or rx_frame_err
//   rx_busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rx,
    input  logic                 rx_negedge_det,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF  = BAUD_DIV >> 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (BAUD_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_fsm: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    logic bit_end;
    logic data_sample;
    logic stop_sample;
    logic cnt_clr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and sampling strobes
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        bit_end     = (cnt == CNT_LAST);
        data_sample = 1'b0;
        stop_sample = 1'b0;

        case (state)
            IDLE: begin
                if (rx_negedge_det) begin
                    next_state = START;
                end
            end
            START: begin
                // Mid-bit re-check; a high line here is a glitch, not a start bit.
                if (cnt == CNT_HALF) begin
                    next_state = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    data_sample = 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    stop_sample = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counter restarts on every state entry and on each DATA bit boundary,
    // so every sample point after START lands one full bit-time later.
    assign cnt_clr = (state == IDLE) || (state != next_state) || data_sample;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bit index and shift register (LSB-first: new bits enter at the MSB)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (state != DATA) begin
                idx <= '0;
            end else if (data_sample) begin
                idx <= idx + 1'b1;
            end
            if (data_sample) begin
                shreg <= {rx, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= stop_sample & rx;
            rx_frame_err <= stop_sample & ~rx;
            if (stop_sample) begin
                rx_data <= shreg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (state == PARITY && bit_end) begin
                par_bit <= rx;
            end
            rx_parity_err <= stop_sample & ((^shreg) ^ 1'(PARITY_ODD) ^ par_bit);
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Randomised frame generator for uart_rx_fsm (BAUD_DIV=16, DATA_BITS=8).
// Frames are described as line waveforms (start, data LSB first, optional
// parity, stop). Expected strobes are queued at the absolute cycle the frame
// timing rules place them; every cycle, the strobes, rx_busy and rx_data are
// compared against that expectation. Follows UART_RX_PARITY_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int BD   = 16;
    localparam int DB   = 8;
    localparam int HALF = BD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB   = DB + 2;
`else
    localparam int NB   = DB + 1;
`endif
    // strobe cycle relative to the edge pulse
    localparam int S    = HALF + NB * BD + 1;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx     = 1'b1;
    logic       det    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    uart_rx_fsm #(
        .BAUD_DIV   (BD),
        .DATA_BITS  (DB),
        .PARITY_ODD (0)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .rx             (rx),
        .rx_negedge_det (det),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_frame_err   (rx_frame_err),
        .rx_parity_err  (rx_parity_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       valid;
        logic       ferr;
        logic       perr;
    } ev_t;

    ev_t        evq[$];
    int         cyc      = 0;
    int         busy_lo  = 0;
    int         busy_hi  = 0;
    logic [7:0] exp_data = 8'h00;
    int         n_cmp    = 0;
    int         n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Compare the current cycle's outputs: flags = {valid, frame_err, parity_err, busy}
    task automatic check_cycle();
        logic [3:0] exp_f;
        exp_f = 4'b0000;
        if (evq.size() > 0 && evq[0].at == cyc) begin
            exp_f[3] = evq[0].valid;
            exp_f[2] = evq[0].ferr;
            exp_f[1] = evq[0].perr;
            exp_data = evq[0].data;
            void'(evq.pop_front());
        end
        exp_f[0] = (cyc >= busy_lo) && (cyc < busy_hi);
        check("flags", {28'b0, rx_valid, rx_frame_err, rx_parity_err, rx_busy}, {28'b0, exp_f});
        check("rx_data", {24'b0, rx_data}, {24'b0, exp_data});
    endtask

    task automatic step(input logic d, input logic r);
        check_cycle();
        det = d;
        rx  = r;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Line level c cycles after the start edge for a well-formed frame
    function automatic logic line_bit(input int c, input logic [7:0] d,
                                      input logic pbit, input logic stop);
        int j;
        j = c / BD;
        if (j == 0) return 1'b0;
        if (j <= DB) return d[j-1];
`ifdef UART_RX_PARITY_EN
        if (j == DB + 1) return pbit;
`endif
        if (j == NB) return stop;
        return 1'b1;
    endfunction

    // fs_len > 0: false start, line low for fs_len cycles only
    task automatic run_frame(input logic [7:0] d, input logic stop, input logic pflip,
                             input int fs_len, input int gap);
        logic pbit;
        ev_t  e;
        int   total;
        logic r;
        pbit    = (^d) ^ pflip;
        busy_lo = cyc + 1;
        if (fs_len > 0) begin
            busy_hi = cyc + HALF + 1;
            total   = HALF + 1 + gap;
        end else begin
            busy_hi = cyc + S;
            e.at    = cyc + S;
            e.data  = d;
            e.valid = stop;
            e.ferr  = ~stop;
`ifdef UART_RX_PARITY_EN
            e.perr  = pflip;
`else
            e.perr  = 1'b0;
`endif
            evq.push_back(e);
            total = S + gap;
        end
        for (int c = 0; c < total; c++) begin
            if (fs_len > 0) r = (c < fs_len) ? 1'b0 : 1'b1;
            else            r = line_bit(c, d, pbit, stop);
            step(c == 0, r);
        end
    endtask

    task automatic reset_mid_frame(input int at);
        busy_lo = cyc + 1;
        busy_hi = cyc + S;
        for (int c = 0; c < at; c++) begin
            step(c == 0, line_bit(c, 8'h5A, ^8'h5A, 1'b1));
        end
        arst_n = 1'b0;
        #1;
        busy_hi  = 0;
        exp_data = 8'h00;
        evq.delete();
        check_cycle();
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);
        arst_n = 1'b1;
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_cycle();
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1);

        // Directed frames
        run_frame(8'hA5, 1'b1, 1'b0, 0, 5);
        run_frame(8'h00, 1'b1, 1'b0, 3, 4);      // false start
        run_frame(8'h3C, 1'b0, 1'b0, 0, 6);      // framing error
        reset_mid_frame(60);
        run_frame(8'h81, 1'b1, 1'b0, 0, 0);
        run_frame(8'hFF, 1'b1, 1'b0, 0, 0);      // back-to-back
        run_frame(8'h01, 1'b1, 1'b0, HALF, 2);   // line high exactly at start sample
`ifdef UART_RX_PARITY_EN
        run_frame(8'h07, 1'b1, 1'b0, 0, 3);
        run_frame(8'h07, 1'b1, 1'b1, 0, 3);
        run_frame(8'h07, 1'b0, 1'b1, 0, 3);
`endif

        // Random frames
        for (int i = 0; i < 40; i++) begin
            int         kind;
            int         fs;
            int         gap;
            logic [7:0] d;
            logic       stop;
            logic       pflip;
            kind  = $urandom_range(0, 9);
            d     = 8'($urandom);
            fs    = (kind < 2) ? $urandom_range(1, HALF) : 0;
            stop  = (kind == 2 || kind == 3) ? 1'b0 : 1'b1;
            pflip = 1'($urandom_range(0, 1));
            gap   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            run_frame(d, stop, pflip, fs, gap);
        end

        for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
        check("pending_strobes", 32'(evq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
